// File: rtl/dac_spi_pkg.sv
// dac_spi_pkg -- shared types and helpers for the multi-channel serial DAC transmitter.
//   state_t      : transmitter FSM states
//   CMD_W/ADDR_W : widths of the command and address fields at the top of every frame
//   build_frame  : assembles {cmd, addr, sample MSB-aligned, zero pad} into a FRAME_MAX-wide,
//                  MSB-aligned vector; the caller keeps the top FRAME_W bits.
package dac_spi_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;

    localparam int CMD_W      = 4;
    localparam int ADDR_W     = 4;
    // Widest frame the helper can assemble; FRAME_W must stay below this.
    localparam int FRAME_MAX  = 64;
    localparam int SAMPLE_MAX = FRAME_MAX - CMD_W - ADDR_W;

    // The sample arrives zero-extended in the low data_w bits and is moved up against
    // the address field, so every bit below it is zero padding.
    function automatic logic [FRAME_MAX-1:0] build_frame(
        input logic [CMD_W-1:0]      cmd,
        input logic [ADDR_W-1:0]     addr,
        input logic [SAMPLE_MAX-1:0] sample,
        input int                    data_w
    );
        logic [SAMPLE_MAX-1:0] aligned;
        aligned = sample << (SAMPLE_MAX - data_w);
        return {cmd, addr, aligned};
    endfunction

endpackage

// File: rtl/dac_spi_clkgen.sv
// dac_spi_clkgen -- SCLK half-period timer.
//   CLK_50  in  system clock
//   RESET   in  synchronous, active-high reset
//   restart in  force the divider back to phase 0 (frame start)
//   run     in  divider counts only while a frame is on the wire
//   tick    out high on the last CLK_50 cycle of each HALF_DIV-cycle half period
module dac_spi_clkgen
    import dac_spi_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic CLK_50,
    input  logic RESET,
    input  logic restart,
    input  logic run,
    output logic tick
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    // Held at zero whenever not running, so the first half period of a frame is always
    // exactly HALF_DIV cycles long regardless of what happened before.
    always_ff @(posedge CLK_50) begin
        if (RESET || restart || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/dac_spi_multi_tx.sv
// dac_spi_multi_tx -- multi-channel serial DAC transmitter.
// Latches NUM_CH samples on one LOAD handshake, then sends one FRAME_W-bit frame per channel
// ({CMD, ADDR=channel, sample MSB-aligned, zero pad}, MSB first) on SYNC/SCLK/DIN,
// channel 0 first, with SYNC held high for GAP_CYC cycles after every frame.
// Ports:
//   CLK_50 in   system clock               RESET in  synchronous, active-high reset
//   LOAD   in   sample-set valid           DATA  in  NUM_CH*DATA_W samples, ch0 in LSBs
//   READY  out  idle, LOAD accepted        BUSY  out transfer in progress
//   DONE   out  1-cycle pulse at end       SYNC  out frame strobe, active low
//   SCLK   out  serial clock, idle low     DIN   out serial data
// Optional feature, macro DAC_SPI_READBACK_EN:
//   SDO in, RDATA out [FRAME_W], RVALID out -- SDO shifted in on every SCLK rise,
//   RDATA loaded and RVALID pulsed when SYNC returns high.
module dac_spi_multi_tx
    import dac_spi_pkg::*;
#(
    parameter int               DATA_W   = 16,
    parameter int               FRAME_W  = 24,
    parameter int               NUM_CH   = 1,
    parameter int               HALF_DIV = 4,
    parameter int               GAP_CYC  = 4,
    parameter logic [CMD_W-1:0] CMD      = 4'h3
) (
    input  logic                     CLK_50,
    input  logic                     RESET,
    input  logic                     LOAD,
    input  logic [NUM_CH*DATA_W-1:0] DATA,
    output logic                     READY,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     SYNC,
    output logic                     SCLK,
    output logic                     DIN
`ifdef DAC_SPI_READBACK_EN
    ,
    input  logic                     SDO,
    output logic [FRAME_W-1:0]       RDATA,
    output logic                     RVALID
`endif
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BIT_W = $clog2(FRAME_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_CYC - 1);

    generate
        if (DATA_W > FRAME_W - CMD_W - ADDR_W || DATA_W < 1 || NUM_CH < 1 || NUM_CH > 16 ||
            HALF_DIV < 1 || GAP_CYC < 1 || FRAME_W >= FRAME_MAX) begin : g_param_err
            $error("dac_spi_multi_tx: illegal parameter combination");
        end
    endgenerate

    state_t                         state;
    logic [NUM_CH-1:0][DATA_W-1:0]  smp_lat;
    logic [CH_W-1:0]                ch;
    logic [BIT_W-1:0]               bit_cnt;
    logic [GAP_W-1:0]               gap_cnt;
    logic [FRAME_W-1:0]             shreg;
    logic                           tick;
    logic                           run;
    logic                           gap_end;

    // ---------------------------------------------------------------- next frame
    // A frame is started either by an accepted LOAD (channel 0, straight from DATA) or by
    // the end of a gap that is not the last channel (next channel, from the latch).
    logic                  start_frame;
    logic [CH_W-1:0]       nxt_ch;
    logic [DATA_W-1:0]     nxt_smp;
    logic [FRAME_MAX-1:0]  frame_full;
    logic [FRAME_W-1:0]    nxt_frame;
    logic                  unused_pad;

    assign gap_end = (state == GAP) && (gap_cnt == LAST_GAP);

    always_comb begin
        start_frame = 1'b0;
        nxt_ch      = '0;
        nxt_smp     = DATA[DATA_W-1:0];
        if (state == IDLE) begin
            start_frame = LOAD;
        end else if (gap_end && ch != LAST_CH) begin
            start_frame = 1'b1;
            nxt_ch      = ch + 1'b1;
            nxt_smp     = smp_lat[nxt_ch];
        end
    end

    assign frame_full = build_frame(CMD, ADDR_W'(nxt_ch), SAMPLE_MAX'(nxt_smp), DATA_W);
    assign nxt_frame  = frame_full[FRAME_MAX-1 -: FRAME_W];
    // Bits below FRAME_W are pad only; the sample limit keeps real data out of them.
    assign unused_pad = ^frame_full[FRAME_MAX-FRAME_W-1:0];

    // ---------------------------------------------------------------- SCLK timer
    assign run = (state == SETUP) || (state == SHIFT_HI) || (state == SHIFT_LO);

    dac_spi_clkgen #(.HALF_DIV(HALF_DIV)) u_clkgen (
        .CLK_50  (CLK_50),
        .RESET   (RESET),
        .restart (start_frame),
        .run     (run),
        .tick    (tick)
    );

    // ---------------------------------------------------------------- FSM
    // bit_cnt counts the bits still to follow the one currently on DIN. DIN advances on
    // the SCLK fall so it is stable around the DAC's rising-edge sample; after the last
    // bit it simply holds until SYNC rises.
    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            state   <= IDLE;
            smp_lat <= '0;
            ch      <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            SYNC    <= 1'b1;
            SCLK    <= 1'b0;
            DIN     <= 1'b0;
            READY   <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (start_frame) begin
                if (state == IDLE) smp_lat <= DATA;
                ch      <= nxt_ch;
                shreg   <= nxt_frame;
                DIN     <= nxt_frame[FRAME_W-1];
                bit_cnt <= BIT_W'(FRAME_W - 1);
                SYNC    <= 1'b0;
                SCLK    <= 1'b0;
                READY   <= 1'b0;
                BUSY    <= 1'b1;
                state   <= SETUP;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    SETUP: begin
                        if (tick) begin
                            SCLK  <= 1'b1;
                            state <= SHIFT_HI;
                        end
                    end
                    SHIFT_HI: begin
                        if (tick) begin
                            SCLK  <= 1'b0;
                            state <= SHIFT_LO;
                            if (bit_cnt != '0) begin
                                shreg <= {shreg[FRAME_W-2:0], 1'b0};
                                DIN   <= shreg[FRAME_W-2];
                            end
                        end
                    end
                    SHIFT_LO: begin
                        if (tick) begin
                            if (bit_cnt == '0) begin
                                SYNC    <= 1'b1;
                                DIN     <= 1'b0;
                                gap_cnt <= '0;
                                state   <= GAP;
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                                SCLK    <= 1'b1;
                                state   <= SHIFT_HI;
                            end
                        end
                    end
                    GAP: begin
                        // A non-last gap end is handled by start_frame above.
                        if (gap_end) begin
                            ch    <= '0;
                            DONE  <= 1'b1;
                            READY <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef DAC_SPI_READBACK_EN
    // ---------------------------------------------------------------- readback
    // SCLK rises on the SETUP tick and on every non-final SHIFT_LO tick; SYNC rises on
    // the final SHIFT_LO tick.
    logic [FRAME_W-1:0] rx_sh;
    logic               sclk_rise;
    logic               frame_end;

    assign sclk_rise = tick && ((state == SETUP) || (state == SHIFT_LO && bit_cnt != '0));
    assign frame_end = tick && (state == SHIFT_LO) && (bit_cnt == '0);

    always_ff @(posedge CLK_50) begin
        if (RESET) begin
            rx_sh  <= '0;
            RDATA  <= '0;
            RVALID <= 1'b0;
        end else begin
            RVALID <= 1'b0;
            if (sclk_rise) rx_sh <= {rx_sh[FRAME_W-2:0], SDO};
            if (frame_end) begin
                RDATA  <= rx_sh;
                RVALID <= 1'b1;
            end
        end
    end
`endif

endmodule
